rtype_issue: RTL and testbench

RTYPE_ISSUE -- requirements
Module: rtype_issue

---
 rtl/cpu_pkg.sv | 64 ++++++
 rtl/rtype_issue_regfile.sv | 48 ++++
 rtl/rtype_issue.sv | 118 +++++++++++
 tb/tb_rtype_issue.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the R-type issue slice:
//   - state_e      : issue FSM state encoding
//   - *_MSB/*_LSB  : bit positions of the R-type instruction fields
//   - FUNCT_*      : function codes understood by the downstream ALU
//   - writesRd()   : tells whether a funct produces a result for R[rd]
// ---------------------------------------------------------------------------
package cpu_pkg;

    localparam int NUM_REGS = 32;
    localparam int REG_AW   = 5;

    localparam int OP_MSB = 31;
    localparam int OP_LSB = 26;
    localparam int RS_MSB = 25;
    localparam int RS_LSB = 21;
    localparam int RT_MSB = 20;
    localparam int RT_LSB = 16;
    localparam int RD_MSB = 15;
    localparam int RD_LSB = 11;
    localparam int SH_MSB = 10;
    localparam int SH_LSB = 6;
    localparam int FN_MSB = 5;
    localparam int FN_LSB = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        FIRE  = 2'd2,
        WB    = 2'd3
    } state_e;

    localparam logic [5:0] FUNCT_SLL  = 6'h00;
    localparam logic [5:0] FUNCT_SRL  = 6'h02;
    localparam logic [5:0] FUNCT_SRA  = 6'h03;
    localparam logic [5:0] FUNCT_MFHI = 6'h10;
    localparam logic [5:0] FUNCT_MFLO = 6'h12;
    localparam logic [5:0] FUNCT_MULT = 6'h18;
    localparam logic [5:0] FUNCT_DIV  = 6'h1A;
    localparam logic [5:0] FUNCT_ADD  = 6'h20;
    localparam logic [5:0] FUNCT_SUB  = 6'h22;
    localparam logic [5:0] FUNCT_AND  = 6'h24;
    localparam logic [5:0] FUNCT_OR   = 6'h25;
    localparam logic [5:0] FUNCT_XOR  = 6'h26;
    localparam logic [5:0] FUNCT_NOR  = 6'h27;
    localparam logic [5:0] FUNCT_SLT  = 6'h2A;

    // mult/div only update the ALU's internal hi/lo pair, and unknown
    // functs must not corrupt the register file, so only the listed
    // result-producing operations write R[rd].
    function automatic logic writesRd(input logic [5:0] funct);
        logic en;
        en = 1'b0;
        case (funct)
            FUNCT_SLL, FUNCT_SRL, FUNCT_SRA, FUNCT_MFHI, FUNCT_MFLO,
            FUNCT_ADD, FUNCT_SUB, FUNCT_AND, FUNCT_OR, FUNCT_XOR,
            FUNCT_NOR, FUNCT_SLT: en = 1'b1;
            default:              en = 1'b0;
        endcase
        return en;
    endfunction

endpackage

// File: rtl/rtype_issue_regfile.sv
// ---------------------------------------------------------------------------
// regfile
// 32 x XLEN register file with R[0] hardwired to zero.
//   clk, rst_n            : clock, asynchronous active-low clear of all regs
//   raddr_a_i / rdata_a_o : combinational read port A (rs)
//   raddr_b_i / rdata_b_o : combinational read port B (rt)
//   raddr_dbg_i / rdata_dbg_o : combinational debug read port
//   we_i, waddr_i, wdata_i: synchronous write port (writes to R[0] dropped)
// ---------------------------------------------------------------------------
module regfile
    import cpu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] raddr_a_i,
    output logic [XLEN-1:0]   rdata_a_o,
    input  logic [REG_AW-1:0] raddr_b_i,
    output logic [XLEN-1:0]   rdata_b_o,
    input  logic [REG_AW-1:0] raddr_dbg_i,
    output logic [XLEN-1:0]   rdata_dbg_o,
    input  logic              we_i,
    input  logic [REG_AW-1:0] waddr_i,
    input  logic [XLEN-1:0]   wdata_i
);

    logic [XLEN-1:0] mem_q [NUM_REGS];

    // Storage: whole array clears on reset; the zero register is never
    // written so it stays at its reset value of 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i && (waddr_i != '0)) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Reads are guarded for address 0 as well, so R[0] reads as zero
    // independent of what the storage cell holds.
    assign rdata_a_o   = (raddr_a_i   == '0) ? '0 : mem_q[raddr_a_i];
    assign rdata_b_o   = (raddr_b_i   == '0) ? '0 : mem_q[raddr_b_i];
    assign rdata_dbg_o = (raddr_dbg_i == '0) ? '0 : mem_q[raddr_dbg_i];

endmodule

// File: rtl/rtype_issue.sv
// ---------------------------------------------------------------------------
// rtype_issue
// Accepts MIPS R-type words, reads rs/rt from the register file, strobes an
// external ALU once and writes its result back to rd. One instruction every
// 4 cycles: accept edge, then ISSUE, FIRE and WB.
//   clk, rst_n       : clock, asynchronous active-low reset
//   instr_valid/instr/instr_ready : instruction handshake (ready only in IDLE)
//   alu_a, alu_b     : R[rs], R[rt] operands to the ALU
//   alu_shamt, alu_funct : shift amount and function code to the ALU
//   alu_go           : registered one-cycle evaluate strobe (FIRE state)
//   alu_out          : ALU result, sampled at the end of WB
//   illegal          : one-cycle pulse when an op != 0 word is rejected
//   dbg_addr/dbg_data: combinational debug read of the register file
// ---------------------------------------------------------------------------
module rtype_issue
    import cpu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            instr_valid,
    input  logic [31:0]     instr,
    output logic            instr_ready,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [4:0]      alu_shamt,
    output logic [5:0]      alu_funct,
    output logic            alu_go,
    input  logic [XLEN-1:0] alu_out,
    output logic            illegal,
    input  logic [4:0]      dbg_addr,
    output logic [XLEN-1:0] dbg_data
);

    state_e            state_q;
    logic [REG_AW-1:0] rdAddr_q;
    logic              wbEn_q;
    logic [XLEN-1:0]   rsData;
    logic [XLEN-1:0]   rtData;
    logic              rfWe;

    // Write back only at the edge that ends WB, when the funct produces
    // a result; alu_out is stable for the whole WB cycle.
    assign rfWe        = (state_q == WB) && wbEn_q;
    assign instr_ready = (state_q == IDLE);

    regfile #(
        .XLEN(XLEN)
    ) u_regfile (
        .clk        (clk),
        .rst_n      (rst_n),
        .raddr_a_i  (instr[RS_MSB:RS_LSB]),
        .rdata_a_o  (rsData),
        .raddr_b_i  (instr[RT_MSB:RT_LSB]),
        .rdata_b_o  (rtData),
        .raddr_dbg_i(dbg_addr),
        .rdata_dbg_o(dbg_data),
        .we_i       (rfWe),
        .waddr_i    (rdAddr_q),
        .wdata_i    (alu_out)
    );

    // Issue FSM. Operands are captured at the accept edge straight from
    // the incoming word, so they are already presented during ISSUE. No
    // write can occur between accept and ISSUE, and the previous WB write
    // has landed before the earliest next accept, so dependent
    // back-to-back instructions read the fresh value without forwarding.
    // Rejected words leave the ALU outputs and latched fields untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_shamt <= '0;
            alu_funct <= '0;
            alu_go    <= 1'b0;
            illegal   <= 1'b0;
            rdAddr_q  <= '0;
            wbEn_q    <= 1'b0;
        end else begin
            illegal <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (instr_valid) begin
                        if (instr[OP_MSB:OP_LSB] != 6'd0) begin
                            illegal <= 1'b1;
                        end else begin
                            alu_a     <= rsData;
                            alu_b     <= rtData;
                            alu_shamt <= instr[SH_MSB:SH_LSB];
                            alu_funct <= instr[FN_MSB:FN_LSB];
                            rdAddr_q  <= instr[RD_MSB:RD_LSB];
                            wbEn_q    <= writesRd(instr[FN_MSB:FN_LSB]);
                            state_q   <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    alu_go  <= 1'b1;
                    state_q <= FIRE;
                end
                FIRE: begin
                    alu_go  <= 1'b0;
                    state_q <= WB;
                end
                WB: begin
                    state_q <= IDLE;
                end
                default: begin
                    alu_go  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rtype_issue.sv
// ---------------------------------------------------------------------------
// tb_rtype_issue
// Directed bench for rtype_issue. A small behavioural ALU answers alu_go;
// it can be overridden with a fixed result to preload registers.
// ---------------------------------------------------------------------------
module tb_rtype_issue;

    logic        clk;
    logic        rst_n;
    logic        instr_valid;
    logic [31:0] instr;
    logic        instr_ready;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [4:0]  alu_shamt;
    logic [5:0]  alu_funct;
    logic        alu_go;
    logic [31:0] alu_out;
    logic        illegal;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;

    int vectors;
    int miscompares;

    logic        forceEn;
    logic [31:0] forceVal;
    logic [31:0] hiReg;
    logic [31:0] loReg;

    rtype_issue #(
        .XLEN(32)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .instr_valid(instr_valid),
        .instr      (instr),
        .instr_ready(instr_ready),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_shamt  (alu_shamt),
        .alu_funct  (alu_funct),
        .alu_go     (alu_go),
        .alu_out    (alu_out),
        .illegal    (illegal),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: evaluates on each clock edge that sees alu_go high.
    // mult returns a junk value on alu_out so a wrongly enabled writeback
    // would be visible in R[rd].
    always @(posedge clk) begin
        if (alu_go) begin
            if (forceEn) begin
                alu_out <= forceVal;
            end else begin
                case (alu_funct)
                    6'h00: alu_out <= alu_b << alu_shamt;
                    6'h02: alu_out <= alu_b >> alu_shamt;
                    6'h03: alu_out <= $signed(alu_b) >>> alu_shamt;
                    6'h10: alu_out <= hiReg;
                    6'h12: alu_out <= loReg;
                    6'h18: begin
                        {hiReg, loReg} <= alu_a * alu_b;
                        alu_out <= 32'hDEADBEEF;
                    end
                    6'h20: alu_out <= alu_a + alu_b;
                    6'h22: alu_out <= alu_a - alu_b;
                    6'h24: alu_out <= alu_a & alu_b;
                    6'h25: alu_out <= alu_a | alu_b;
                    6'h26: alu_out <= alu_a ^ alu_b;
                    6'h27: alu_out <= ~(alu_a | alu_b);
                    6'h2A: alu_out <= {31'd0, $signed(alu_a) < $signed(alu_b)};
                    default: alu_out <= 32'hDEADBEEF;
                endcase
            end
        end
    end

    // One comparison point: counts the vector and reports on mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Offers a word at the negedge; returns 1 ns after the accept edge.
    task automatic applyStimulus(input logic [31:0] word);
        @(negedge clk);
        instr_valid = 1'b1;
        instr       = word;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
    endtask

    // Full instruction: returns 1 ns after the WB-ending edge (back in IDLE).
    task automatic runInstr(input logic [31:0] word);
        applyStimulus(word);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic checkReg(input string tag, input logic [4:0] addr,
                            input logic [31:0] expected);
        dbg_addr = addr;
        #1;
        checkOutput(tag, dbg_data, expected);
    endtask

    // Preloads R[rd] by issuing "or rd, r0, r0" with a forced ALU result.
    task automatic loadReg(input logic [4:0] rd, input logic [31:0] value);
        forceVal = value;
        forceEn  = 1'b1;
        runInstr({6'd0, 5'd0, 5'd0, rd, 5'd0, 6'h25});
        forceEn  = 1'b0;
    endtask

    function automatic logic [31:0] rword(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] sh,
                                          input logic [5:0] fn);
        return {6'd0, rs, rt, rd, sh, fn};
    endfunction

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        instr       = '0;
        dbg_addr    = '0;
        alu_out     = '0;
        forceEn     = 1'b0;
        forceVal    = '0;
        hiReg       = '0;
        loReg       = '0;

        // Reset state
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("rst_ready", {31'd0, instr_ready}, 32'd1);
        checkOutput("rst_go", {31'd0, alu_go}, 32'd0);
        checkOutput("rst_illegal", {31'd0, illegal}, 32'd0);
        checkOutput("rst_alu_a", alu_a, 32'd0);
        for (int i = 0; i < 32; i++) begin
            checkReg($sformatf("rst_R%0d", i), i[4:0], 32'd0);
        end

        // add R3 = R1 + R2 with cycle-by-cycle timing
        loadReg(5'd1, 32'd5);
        loadReg(5'd2, 32'd3);
        checkReg("load_R1", 5'd1, 32'd5);
        checkReg("load_R2", 5'd2, 32'd3);
        applyStimulus(rword(5'd1, 5'd2, 5'd3, 5'd0, 6'h20));
        checkOutput("add_issue_a", alu_a, 32'd5);
        checkOutput("add_issue_b", alu_b, 32'd3);
        checkOutput("add_issue_fn", {26'd0, alu_funct}, 32'h20);
        checkOutput("add_issue_go", {31'd0, alu_go}, 32'd0);
        checkOutput("add_issue_rdy", {31'd0, instr_ready}, 32'd0);
        @(posedge clk); #1;
        checkOutput("add_fire_go", {31'd0, alu_go}, 32'd1);
        checkOutput("add_fire_a", alu_a, 32'd5);
        @(posedge clk); #1;
        checkOutput("add_wb_go", {31'd0, alu_go}, 32'd0);
        checkOutput("add_wb_rdy", {31'd0, instr_ready}, 32'd0);
        @(posedge clk); #1;
        checkOutput("add_idle_rdy", {31'd0, instr_ready}, 32'd1);
        checkReg("add_R3", 5'd3, 32'd8);

        // sll then dependent sub issued immediately
        loadReg(5'd1, 32'd1);
        runInstr(rword(5'd0, 5'd1, 5'd4, 5'd4, 6'h00));
        runInstr(rword(5'd4, 5'd1, 5'd5, 5'd0, 6'h22));
        checkReg("sll_R4", 5'd4, 32'h10);
        checkReg("sub_R5", 5'd5, 32'hF);

        // mult suppresses writeback; mflo delivers low word
        runInstr(rword(5'd4, 5'd5, 5'd6, 5'd0, 6'h18));
        checkReg("mult_R6", 5'd6, 32'd0);
        runInstr(rword(5'd0, 5'd0, 5'd6, 5'd0, 6'h12));
        checkReg("mflo_R6", 5'd6, 32'hF0);

        // illegal op: one-cycle pulse, nothing else moves
        applyStimulus({6'h23, 5'd1, 5'd7, 5'd7, 5'd0, 6'h20});
        checkOutput("ill_pulse", {31'd0, illegal}, 32'd1);
        checkOutput("ill_rdy", {31'd0, instr_ready}, 32'd1);
        checkOutput("ill_alu_a", alu_a, 32'd0);
        checkOutput("ill_alu_fn", {26'd0, alu_funct}, 32'h12);
        @(posedge clk); #1;
        checkOutput("ill_pulse_end", {31'd0, illegal}, 32'd0);
        checkOutput("ill_go", {31'd0, alu_go}, 32'd0);
        @(posedge clk); #1;
        checkOutput("ill_go2", {31'd0, alu_go}, 32'd0);
        checkReg("ill_R7", 5'd7, 32'd0);
        checkReg("ill_R1", 5'd1, 32'd1);
        checkReg("ill_R6", 5'd6, 32'hF0);

        // add to R0 is dropped
        runInstr(rword(5'd4, 5'd5, 5'd0, 5'd0, 6'h20));
        checkReg("r0_R0", 5'd0, 32'd0);
        checkReg("r0_R4", 5'd4, 32'h10);

        // instr_valid ignored while busy
        applyStimulus(rword(5'd1, 5'd1, 5'd8, 5'd0, 6'h20));
        @(negedge clk);
        instr_valid = 1'b1;
        instr       = {6'h23, 5'd1, 5'd1, 5'd9, 5'd0, 6'h20};
        @(posedge clk); #1;
        checkOutput("busy_ill_fire", {31'd0, illegal}, 32'd0);
        @(posedge clk); #1;
        checkOutput("busy_ill_wb", {31'd0, illegal}, 32'd0);
        instr_valid = 1'b0;
        @(posedge clk); #1;
        checkOutput("busy_ill_idle", {31'd0, illegal}, 32'd0);
        checkOutput("busy_rdy", {31'd0, instr_ready}, 32'd1);
        checkReg("busy_R8", 5'd8, 32'd2);
        checkReg("busy_R9", 5'd9, 32'd0);

        // reset dropped during FIRE
        applyStimulus(rword(5'd1, 5'd1, 5'd10, 5'd0, 6'h20));
        @(posedge clk); #1;
        checkOutput("rstf_go_before", {31'd0, alu_go}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rstf_go", {31'd0, alu_go}, 32'd0);
        checkOutput("rstf_rdy", {31'd0, instr_ready}, 32'd1);
        checkOutput("rstf_alu_a", alu_a, 32'd0);
        checkOutput("rstf_alu_fn", {26'd0, alu_funct}, 32'd0);
        checkReg("rstf_R1", 5'd1, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("rstf_rdy_after", {31'd0, instr_ready}, 32'd1);
        checkOutput("rstf_go_after", {31'd0, alu_go}, 32'd0);
        checkReg("rstf_R10", 5'd10, 32'd0);

        // block still works after the abort
        loadReg(5'd11, 32'd7);
        checkReg("post_R11", 5'd11, 32'd7);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
